// File: rtl/dac_pwm_if.sv
// Sample and carrier-frequency load bus for dac_pwm_multi.
// The master drives samples and frequency words; the DAC is the slave.
interface dac_pwm_if #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
);
  logic [W-1:0]   fre_word_in;
  logic           fre_load;
  logic [N*W-1:0] data_in;
  logic           data_valid;
  logic           data_ready;

  modport master (
    output fre_word_in,
    output fre_load,
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  fre_word_in,
    input  fre_load,
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/dac_pwm_multi.sv
// Multi-channel PWM DAC on a shared phase accumulator. Samples and frequency
// words are double-buffered and only take effect on a carrier wrap.
module dac_pwm_multi #(
  parameter int unsigned MAIN_FRE    = 500,
  parameter int unsigned PWM_FRE     = 1000,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CENTER      = 0,
  parameter int unsigned INTERLEAVE  = 0
) (
  input  logic                clk_in,
  input  logic                RST,
  dac_pwm_if.slave            bus,
  output logic [CHANNELS-1:0] DAC_PWM,
  output logic                period_start
);

  localparam int unsigned W     = PHASE_WIDTH;
  localparam int unsigned CalcW = PHASE_WIDTH + 64;

  // Reset carrier word: floor(2^W * PWM_FRE / (MAIN_FRE * 1000)), truncated.
  localparam logic [CalcW-1:0] FreNum = CalcW'(PWM_FRE) << PHASE_WIDTH;
  localparam logic [CalcW-1:0] FreDen = CalcW'(MAIN_FRE) * CalcW'(1000);
  localparam logic [W-1:0]     FreDef = W'(FreNum / FreDen);

  localparam logic [W:0]   PhaseSpan = {1'b1, {W{1'b0}}};
  localparam logic [W-1:0] PhaseStep = W'(PhaseSpan / (W + 1)'(CHANNELS));
  localparam logic [W-1:0] Mid       = {1'b1, {(W - 1){1'b0}}};

  logic [W-1:0]        addr_q, addr_d;
  logic [W-1:0]        fre_q, fre_sh_q;
  logic [W-1:0]        duty_act_q [CHANNELS];
  logic [W-1:0]        duty_sh_q  [CHANNELS];
  logic                pending_q, pending_d;
  logic                ready_q, ready_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                ps_q;

  logic                wrap;
  logic                xfer;
  logic                apply;
  logic [W-1:0]        phase   [CHANNELS];
  logic [W-1:0]        carrier [CHANNELS];

  always_comb begin
    {wrap, addr_d} = {1'b0, addr_q} + {1'b0, fre_q};
    xfer           = bus.data_valid & ready_q;
    apply          = wrap & pending_q;
    pending_d      = xfer | (pending_q & ~wrap);
    ready_d        = ~pending_d;
    pwm_d          = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      phase[k] = addr_q;
      if (INTERLEAVE != 0) begin
        phase[k] = addr_q + W'(k) * PhaseStep;
      end
      carrier[k] = phase[k];
      // Triangle: fold the upper half back down, doubling the slope.
      if (CENTER != 0) begin
        carrier[k] = {phase[k][W-1] ? ~phase[k][W-2:0] : phase[k][W-2:0], 1'b0};
      end
      pwm_d[k] = carrier[k] < duty_act_q[k];
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      addr_q    <= '0;
      fre_q     <= FreDef;
      fre_sh_q  <= FreDef;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      pwm_q     <= '0;
      ps_q      <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        duty_act_q[k] <= Mid;
        duty_sh_q[k]  <= Mid;
      end
    end else begin
      addr_q    <= addr_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      pwm_q     <= pwm_d;
      ps_q      <= wrap;
      if (bus.fre_load) begin
        fre_sh_q <= bus.fre_word_in;
      end
      if (wrap) begin
        fre_q <= fre_sh_q;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (apply) begin
          duty_act_q[k] <= duty_sh_q[k];
        end
        // Offset binary: flipping the sign bit adds 2^(W-1) modulo 2^W.
        if (xfer) begin
          duty_sh_q[k] <= bus.data_in[k*W +: W] ^ Mid;
        end
      end
    end
  end

  assign bus.data_ready = ready_q;
  assign DAC_PWM        = pwm_q;
  assign period_start   = ps_q;

endmodule

// File: tb/tb_dac_pwm_multi.sv
// Directed bench: W=8, N=2, carrier word 16 after reset. dut0 is edge-aligned,
// dut1 is center-aligned with interleave; both share the same stimulus.
module tb_dac_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pwm0, pwm1;
  logic       ps0, ps1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  dac_pwm_if #(.W(8), .N(2)) bus0 ();
  dac_pwm_if #(.W(8), .N(2)) bus1 ();

  assign bus1.fre_word_in = bus0.fre_word_in;
  assign bus1.fre_load    = bus0.fre_load;
  assign bus1.data_in     = bus0.data_in;
  assign bus1.data_valid  = bus0.data_valid;

  // MAIN_FRE=8 kHz, PWM_FRE=500 Hz -> FRE_DEF = 256*500/8000 = 16.
  dac_pwm_multi #(
    .MAIN_FRE(8), .PWM_FRE(500), .PHASE_WIDTH(8), .CHANNELS(2), .CENTER(0), .INTERLEAVE(0)
  ) dut0 (
    .clk_in(clk), .RST(rst), .bus(bus0.slave), .DAC_PWM(pwm0), .period_start(ps0)
  );

  dac_pwm_multi #(
    .MAIN_FRE(8), .PWM_FRE(500), .PHASE_WIDTH(8), .CHANNELS(2), .CENTER(1), .INTERLEAVE(1)
  ) dut1 (
    .clk_in(clk), .RST(rst), .bus(bus1.slave), .DAC_PWM(pwm1), .period_start(ps1)
  );

  typedef struct {
    logic [15:0] data;  // {ch1, ch0} samples
    logic [15:0] e00;   // dut0 ch0 pattern, bit i = carrier step i
    logic [15:0] e01;
    logic [15:0] e10;   // dut1 ch0
    logic [15:0] e11;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus0.data_ready && n < 64) begin
      tick();
      n++;
    end
    check("wait data_ready", {31'd0, bus0.data_ready}, 32'd1);
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ps0 && n < 64);
    check("wait period_start", {31'd0, ps0}, 32'd1);
  endtask

  task automatic count_period(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ps0 && n < 100);
  endtask

  task automatic transfer(input logic [15:0] d);
    wait_ready();
    bus0.data_in    = d;
    bus0.data_valid = 1'b1;
    tick();
    bus0.data_valid = 1'b0;
  endtask

  // Starts on a period_start cycle; records one full carrier period.
  task automatic capture(output logic [15:0] p00, output logic [15:0] p01,
                         output logic [15:0] p10, output logic [15:0] p11,
                         output logic ps_ok);
    ps_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      p00[i] = pwm0[0];
      p01[i] = pwm0[1];
      p10[i] = pwm1[0];
      p11[i] = pwm1[1];
      if (ps0 != (i == 15)) ps_ok = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] p00, p01, p10, p11;
    logic        ps_ok;
    int          n, bad_ready, bad_ps, bad_pwm;

    vecs[0] = '{16'h0000, 16'h00FF, 16'h00FF, 16'hF00F, 16'h0FF0};
    vecs[1] = '{16'h7F80, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[2] = '{16'hC040, 16'h0FFF, 16'h000F, 16'hFC3F, 16'h03C0};
    vecs[3] = '{16'hFF01, 16'h01FF, 16'h00FF, 16'hF01F, 16'h0FF0};
    vecs[4] = '{16'h10F0, 16'h007F, 16'h01FF, 16'hE00F, 16'h1FF0};

    rst              = 1'b1;
    bus0.fre_word_in = '0;
    bus0.fre_load    = 1'b0;
    bus0.data_in     = '0;
    bus0.data_valid  = 1'b0;
    tick();
    tick();
    check("reset DAC_PWM", {30'd0, pwm0}, 32'd0);
    check("reset period_start", {31'd0, ps0}, 32'd0);
    check("reset data_ready", {31'd0, bus0.data_ready}, 32'd0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      transfer(vecs[v].data);
      wait_ps();
      check($sformatf("v%0d ready after wrap", v), {31'd0, bus0.data_ready}, 32'd1);
      capture(p00, p01, p10, p11, ps_ok);
      check($sformatf("v%0d period_start spacing", v), {31'd0, ps_ok}, 32'd1);
      check($sformatf("v%0d edge ch0", v), {16'd0, p00}, {16'd0, vecs[v].e00});
      check($sformatf("v%0d edge ch1", v), {16'd0, p01}, {16'd0, vecs[v].e01});
      check($sformatf("v%0d center ch0", v), {16'd0, p10}, {16'd0, vecs[v].e10});
      check($sformatf("v%0d center ch1", v), {16'd0, p11}, {16'd0, vecs[v].e11});
    end

    // Double buffer: sample 64 mid-period, then a rejected -128 held on the bus.
    bad_ready = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        bus0.data_in    = 16'h4040;
        bus0.data_valid = 1'b1;
      end
      tick();
      p00[i] = pwm0[0];
      p01[i] = pwm0[1];
      if (i == 4) begin
        check("ready drops on transfer", {31'd0, bus0.data_ready}, 32'd0);
        bus0.data_in = 16'h8080;
      end else if (i > 4 && i < 15 && bus0.data_ready) begin
        bad_ready++;
      end
    end
    check("ready low while pending", bad_ready, 0);
    check("ready 1 cycle after wrap", {31'd0, bus0.data_ready}, 32'd1);
    check("wrap after mid-period load", {31'd0, ps0}, 32'd1);
    bus0.data_valid = 1'b0;
    check("old duty ch0 until wrap", {16'd0, p00}, 32'h007F);
    check("old duty ch1 until wrap", {16'd0, p01}, 32'h01FF);
    capture(p00, p01, p10, p11, ps_ok);
    check("sample 64 ch0 12 high", {16'd0, p00}, 32'h0FFF);
    check("sample 64 ch1 12 high", {16'd0, p01}, 32'h0FFF);
    capture(p00, p01, p10, p11, ps_ok);
    check("second sample rejected", {16'd0, p00}, 32'h0FFF);

    // Frequency change mid-period: current period keeps 16 cycles.
    n = 0;
    do begin
      bus0.fre_load    = (n == 3);
      bus0.fre_word_in = 8'd32;
      tick();
      n++;
    end while (!ps0 && n < 64);
    bus0.fre_load = 1'b0;
    check("period before fre change", n, 16);
    count_period(n);
    check("period at fre 32 (1)", n, 8);
    count_period(n);
    check("period at fre 32 (2)", n, 8);

    // Two loads in one period: the later one wins.
    n = 0;
    do begin
      bus0.fre_load    = (n == 1) || (n == 3);
      bus0.fre_word_in = (n == 1) ? 8'd48 : 8'd64;
      tick();
      n++;
    end while (!ps0 && n < 64);
    bus0.fre_load = 1'b0;
    check("period with double load", n, 8);
    count_period(n);
    check("period at fre 64", n, 4);

    // Freeze: fre_word 0 stops the carrier; a new sample stays pending.
    n = 0;
    do begin
      bus0.fre_load    = (n == 0);
      bus0.fre_word_in = 8'd0;
      tick();
      n++;
    end while (!ps0 && n < 64);
    bus0.fre_load = 1'b0;
    check("period before freeze", n, 4);
    transfer(16'h8080);
    bad_ps    = 0;
    bad_ready = 0;
    bad_pwm   = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ps0) bad_ps++;
      if (bus0.data_ready) bad_ready++;
      if (pwm0[0] !== 1'b1) bad_pwm++;
    end
    check("frozen: no period_start", bad_ps, 0);
    check("frozen: sample stays pending", bad_ready, 0);
    check("frozen: output holds old duty", bad_pwm, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset from freeze DAC_PWM", {30'd0, pwm0}, 32'd0);
    tick();
    check("ready after release", {31'd0, bus0.data_ready}, 32'd1);
    count_period(n);
    check("period is FRE_DEF after reset", n, 15);

    // Reset mid-period with a pending sample.
    repeat (5) tick();
    transfer(16'h8080);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset DAC_PWM", {30'd0, pwm0}, 32'd0);
    check("mid reset data_ready", {31'd0, bus0.data_ready}, 32'd0);
    check("mid reset period_start", {31'd0, ps0}, 32'd0);
    tick();
    check("ready after mid reset", {31'd0, bus0.data_ready}, 32'd1);
    count_period(n);
    check("period after mid reset", n, 15);
    capture(p00, p01, p10, p11, ps_ok);
    check("post-reset ps spacing", {31'd0, ps_ok}, 32'd1);
    check("post-reset ch0 mid-scale", {16'd0, p00}, 32'h00FF);
    check("post-reset ch1 mid-scale", {16'd0, p01}, 32'h00FF);
    capture(p00, p01, p10, p11, ps_ok);
    check("discarded sample never applied", {16'd0, p00}, 32'h00FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dac_pwm_multi.md
# dac_pwm_multi

Multi-channel PWM DAC with a phase-accumulator carrier, for driving several RC-filtered analog outputs (bias, audio, motor references) from a single clock. Each channel converts a signed sample to a duty cycle. New samples and new carrier frequencies are double-buffered and take effect only at a carrier period boundary, so every PWM period is glitch-free. Carrier can be edge-aligned (sawtooth) or center-aligned (triangle), with optional per-channel phase interleave to spread switching edges.

## Interface
- MAIN_FRE, 500: clock frequency in kHz; used only to compute the reset carrier word.
- PWM_FRE, 1000: default carrier frequency in Hz.
- PHASE_WIDTH, 32: accumulator, sample and duty width W.
- CHANNELS, 4: number of PWM outputs N (≥1).
- CENTER, 0: 0 = edge-aligned sawtooth, 1 = center-aligned triangle.
- INTERLEAVE, 0: 1 = channel k phase offset by k·floor(2^W/N).
- clk_in  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- fre_word_in  in  W  carrier phase increment, unsigned.
- fre_load  in  1  capture fre_word_in into the frequency shadow register.
- data_in  in  N·W  channel k sample in bits [k·W+W-1 : k·W], two's complement.
- data_valid  in  1  data_in valid.
- data_ready  out  1  shadow sample buffer free.
- DAC_PWM  out  N  registered PWM outputs.
- period_start  out  1  one-cycle pulse at the first cycle of each carrier period.

## Operation
- FRE_DEF = floor(2^W·PWM_FRE/(MAIN_FRE·1000)), truncated to W bits.
- Accumulator addr_r (W bits) adds fre_word_r every cycle, modulo 2^W. wrap = carry-out of that add.
- Channel phase p_k = addr_r + (INTERLEAVE ? k·floor(2^W/N) : 0), modulo 2^W.
- Carrier c_k:
  - CENTER=0: c_k = p_k.
  - CENTER=1: c_k = {p_k[W-1] ? ~p_k[W-2:0] : p_k[W-2:0], 1'b0}.
- Duty: duty = sample + 2^(W-1), modulo 2^W (offset binary). −2^(W-1) → 0, 0 → mid-scale, +2^(W-1)−1 → 2^W−1.
- Output rule: DAC_PWM[k] = (c_k < duty_act_k). Duty 0 gives constant low.
- Sample handshake: a transfer occurs when data_valid & data_ready. The sample is converted to duty and stored in shadow registers, pending is set, and data_ready drops.
- Apply rule: on a wrap cycle with pending=1, duty_act ← shadow and pending is cleared. data_ready rises the following cycle.
- Simultaneous transfer and wrap with pending=0: the sample enters the shadow only and is applied at the next wrap.
- Frequency: fre_load writes fre_shadow; if fre_load is asserted repeatedly, the last write before the wrap wins. On a wrap, fre_word_r ← fre_shadow.
- fre_word = 0 freezes addr_r. No wrap occurs, so pending samples stay pending.

## Timing
- Reset values:
  - addr_r = 0, fre_word_r = fre_shadow = FRE_DEF.
  - duty_act = duty shadow = 2^(W-1) (sample 0).
  - pending = 0.
  - DAC_PWM = 0, period_start = 0, data_ready = 0 during RST, 1 in the first cycle after RST.
- Reset has priority over all other inputs, including mid-period and mid-handshake. Any pending sample is discarded.
- DAC_PWM and period_start are registered. The cycle-n+1 value reflects addr_r, duty_act and wrap of cycle n.
- A sample accepted at cycle t appears on DAC_PWM no earlier than 2 cycles after the next wrap at or after t+1.
- Throughput: one sample per carrier period.

## Test plan
- W=8, N=2, CENTER=0, INTERLEAVE=0, fre_word=16, sample 0 on both channels → every 16-cycle period has 8 high then 8 low. period_start pulses every 16 cycles.
- Same setup, samples −128 and +127 → ch0 constant low; ch1 high on all 16 steps (phase max is 240 < 255).
- CENTER=1, sample 0 → high for phases {0,16,32,48,192,208,224,240}, i.e. 4 low-end plus 4 high-end steps, centered on the phase-0 step. INTERLEAVE=1 → ch1 identical to ch0 delayed by 8 cycles.
- Double buffer:
  - Present sample 64 mid-period → data_ready low, output unchanged until the wrap.
  - Next period has 12 high steps; data_ready high 1 cycle after the wrap.
  - A second valid sample while data_ready is low is not accepted.
- Frequency change: fre_load 32 mid-period → current period stays 16 cycles; subsequent periods are 8 cycles. Write 0 → addr_r holds, no period_start, pending sample stays pending.
- Assert RST mid-period with pending=1 → next cycle DAC_PWM=0, addr_r=0, data_ready=0. After release, duty is mid-scale, fre_word=FRE_DEF, and the old sample is never applied.
